torus_router_p: RTL and testbench
=================================

TORUS_ROUTER_P -- requirements
Module: torus_router_p

Interface
REQ-001 Parameter NX, default 4: torus columns.
REQ-002 Parameter NY, default 4: torus rows.
REQ-003 Parameter DW, default 8: payload width.
REQ-004 Parameter DEPTH, default 4: per-input FIFO depth in flits, a power of two and at least 2.
REQ-005 Derived: XW=$clog2(NX), YW=$clog2(NY), FW=XW+YW+DW; flit = {dst_x[XW], dst_y[YW], payload[DW]}.
REQ-006 clk  input  1  sole clock; all state updates on posedge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 my_x  input  XW  this node's column, static after reset.
REQ-009 my_y  input  YW  this node's row, static after reset.
REQ-010 in_data  input  5*FW  flit per input port; port p occupies bits [p*FW +: FW]; ports 0=L, 1=E, 2=W, 3=N, 4=S.
REQ-011 in_valid  input  5  flit present per input port.
REQ-012 in_ready  output  5  input FIFO not full per port.
REQ-013 out_data  output  5*FW  registered flit per output port, same port order as in_data.
REQ-014 out_valid  output  5  output register holds a flit.
REQ-015 out_ready  input  5  downstream accepts the flit.

Function
REQ-016 An input transfer SHALL occur on a posedge with in_valid[p]&&in_ready[p]; the flit is written to FIFO p.
REQ-017 in_ready[p] SHALL be derived from registered FIFO occupancy only: high when count<DEPTH, with no combinational path from in_valid.
REQ-018 The head of each non-empty FIFO SHALL compute one output port, X dimension first, as follows.
- de=(dst_x-my_x) mod NX.
- de==0: go to the Y step.
- de<=NX/2: E.
- Otherwise: W.
REQ-019 Y step SHALL be:
- ds=(dst_y-my_y) mod NY.
- ds==0: L.
- ds<=NY/2: S.
- Otherwise: N.
- S is the increasing-y direction.
REQ-020 Output o SHALL be free when out_valid[o]==0 or out_ready[o]==1.
REQ-021 Each free output SHALL grant one requesting head per cycle, round-robin over input index. The pointer moves to the winner+1 after each grant and is unchanged when there is no grant.
REQ-022 On a grant, the output register SHALL load the flit, out_valid SHALL be 1, and the head SHALL pop, all on the same edge.
REQ-023 out_data[o] and out_valid[o] SHALL hold stable while out_valid[o]&&!out_ready[o].
REQ-024 Latency SHALL be 2 edges. A flit accepted at edge k into an empty FIFO, with a free, uncontended output, shows out_valid at edge k+1.
REQ-025 Throughput SHALL be one flit per output per cycle, including back-to-back refill while out_ready stays high.
REQ-026 A simultaneous push and pop on a non-empty FIFO SHALL leave its count unchanged. A push into an empty FIFO SHALL make that flit eligible for arbitration on the next edge.
REQ-027 A full FIFO SHALL drop nothing. A push attempted while in_ready is low SHALL be ignored.
REQ-028 FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-029 Different outputs SHALL be granted independently in the same cycle. A blocked head SHALL block only its own FIFO.

Reset
REQ-030 On rst low, all of the following SHALL clear asynchronously and hold while rst is low:
- FIFO counts and pointers.
- Round-robin pointers (set to 0).
- out_valid (set to 0) and out_data (set to 0).
- in_ready (set to 0).
REQ-031 After rst rises, in_ready SHALL be 5'b11111 from the first posedge. Flits in flight at reset assertion are discarded.

Configuration
REQ-032 Macro TORUS_WRAP_EN SHALL select the routing mode.
- Defined: wrap-around shortest-path routing as REQ-018/019.
- Undefined: mesh XY routing. X uses E if dst_x>my_x, W if dst_x<my_x, else Y. Y uses S if dst_y>my_y, N if dst_y<my_y, else L.

Structure
REQ-033 Package torus_pkg SHALL hold the port index constants P_L, P_E, P_W, P_N, P_S, the value NPORTS=5, and the flit field-extraction functions.
REQ-034 Sub-module torus_fifo (parameters FW, DEPTH; ports clk, rst, push, pop, din, dout, count) SHALL be instantiated five times. Routing, arbitration and output registers live in torus_router_p.

Verification
REQ-035 NX=NY=4, my=(1,1), L injects dst (3,1) payload 8'hA5 -> out_valid[E]=1 two edges later with out_data payload A5.
REQ-036 my=(0,0), L injects dst (3,0) -> with TORUS_WRAP_EN the flit exits W; without the macro it exits E.
REQ-037 E, N and S inputs each send a flit to dst=my (local) on the same edge -> L emits them in round-robin order E, N, S over three consecutive cycles.
REQ-038 out_ready[S]=0 and L pushes dst (1,2) six times with DEPTH=4 -> in_ready[0] drops after 5 accepted flits (4 in the FIFO plus 1 in the output register); releasing out_ready delivers all 5 in order, none lost.
REQ-039 rst pulsed low mid-burst with the FIFOs half full -> out_valid=0 immediately; no stale flit appears after reset; in_ready=5'b11111.

Source files
------------

// File: rtl/torus_pkg.sv
// torus_pkg: port indices, flit field helpers and round-robin index helper for torus_router_p
//   P_L/P_E/P_W/P_N/P_S : port numbers (0..4), NPORTS = 5
//   flit layout          : {dst_x[xw], dst_y[yw], payload[dw]}
package torus_pkg;
   localparam int NPORTS = 5;
   localparam int P_L = 0;
   localparam int P_E = 1;
   localparam int P_W = 2;
   localparam int P_N = 3;
   localparam int P_S = 4;
   localparam int MAXW = 64;
   typedef logic [MAXW-1:0] wide_t;
   typedef logic [2:0] port_t;

   function automatic wide_t field_mask(int w);
      return (wide_t'(1) << w) - wide_t'(1);
   endfunction

   function automatic wide_t flit_x(wide_t f, int xw, int yw, int dw);
      return (f >> (yw + dw)) & field_mask(xw);
   endfunction

   function automatic wide_t flit_y(wide_t f, int yw, int dw);
      return (f >> dw) & field_mask(yw);
   endfunction

   function automatic wide_t flit_payload(wide_t f, int dw);
      return f & field_mask(dw);
   endfunction

   // Port index k steps after base, wrapping over the five ports.
   function automatic port_t rr_idx(port_t base, int k);
      int s;
      s = int'(base) + k;
      return port_t'(s >= NPORTS ? s - NPORTS : s);
   endfunction
endpackage

// File: rtl/torus_fifo.sv
// torus_fifo: per-input flit FIFO with first-word-fall-through head
//   clk, rst (async active-low) ; push/din write when not full ; pop drops the head when non-empty
//   dout = current head ; count = registered occupancy (0..DEPTH)
module torus_fifo #(
   parameter int FW = 12,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [FW-1:0] din,
   output logic [FW-1:0] dout,
   output logic [CW-1:0] count
);
   logic [FW-1:0] mem [DEPTH];
   logic [AW-1:0] rp, wp;
   logic wr, rd;
   assign wr = push && count < CW'(DEPTH);
   assign rd = pop && count != '0;
   assign dout = mem[rp];
   // Power-of-two depth lets the pointers wrap modulo DEPTH on their own.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         rp <= '0;
         wp <= '0;
         count <= '0;
      end else begin
         if (wr) wp <= wp + AW'(1);
         if (rd) rp <= rp + AW'(1);
         count <= count + CW'(wr) - CW'(rd);
      end
   always_ff @(posedge clk)
      if (wr) mem[wp] <= din;
endmodule

// File: rtl/torus_router_p.sv
// torus_router_p: 5-port torus/mesh router node, input FIFOs, dimension-order routing, round-robin output arbitration
//   clk ; rst (async active-low) ; my_x/my_y node coordinates
//   in_data/in_valid/in_ready  : five input ports {L,E,W,N,S}, flit per FW slice
//   out_data/out_valid/out_ready : five registered output ports, same order
//   TORUS_WRAP_EN defined -> shortest-path wrap-around routing; undefined -> mesh XY routing
module torus_router_p import torus_pkg::*; #(
   parameter int NX = 4,
   parameter int NY = 4,
   parameter int DW = 8,
   parameter int DEPTH = 4,
   localparam int XW = $clog2(NX),
   localparam int YW = $clog2(NY),
   localparam int FW = XW + YW + DW
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [XW-1:0]      my_x,
   input  logic [YW-1:0]      my_y,
   input  logic [5*FW-1:0]    in_data,
   input  logic [4:0]         in_valid,
   output logic [4:0]         in_ready,
   output logic [5*FW-1:0]    out_data,
   output logic [4:0]         out_valid,
   input  logic [4:0]         out_ready
);
   localparam int CW = $clog2(DEPTH) + 1;
   logic [FW-1:0] head [NPORTS];
   logic [CW-1:0] cnt [NPORTS];
   logic [FW-1:0] oq [NPORTS];
   port_t dir [NPORTS];
   port_t win [NPORTS];
   port_t ptr [NPORTS];
   logic [NPORTS-1:0] push, pop, hv, free, gnt;
   // Holds in_ready low through reset and until the first edge after release.
   logic alive;

   for (genvar g = 0; g < NPORTS; g++) begin : g_port
      logic [XW-1:0] dx;
      logic [YW-1:0] dy;
      torus_fifo #(.FW(FW), .DEPTH(DEPTH)) u_fifo (
         .clk(clk),
         .rst(rst),
         .push(push[g]),
         .pop(pop[g]),
         .din(in_data[g*FW +: FW]),
         .dout(head[g]),
         .count(cnt[g])
      );
      assign hv[g] = cnt[g] != '0;
      assign in_ready[g] = alive && cnt[g] < CW'(DEPTH);
      assign push[g] = in_valid[g] && in_ready[g];
      assign free[g] = !out_valid[g] || out_ready[g];
      assign out_data[g*FW +: FW] = oq[g];
      assign dx = XW'(flit_x(wide_t'(head[g]), XW, YW, DW));
      assign dy = YW'(flit_y(wide_t'(head[g]), YW, DW));
`ifdef TORUS_WRAP_EN
      int de, ds;
      assign de = (int'(dx) - int'(my_x) + NX) % NX;
      assign ds = (int'(dy) - int'(my_y) + NY) % NY;
      assign dir[g] = de != 0 ? (de <= NX / 2 ? port_t'(P_E) : port_t'(P_W)) :
                      ds == 0 ? port_t'(P_L) :
                      ds <= NY / 2 ? port_t'(P_S) : port_t'(P_N);
`else
      assign dir[g] = dx > my_x ? port_t'(P_E) :
                      dx < my_x ? port_t'(P_W) :
                      dy > my_y ? port_t'(P_S) :
                      dy < my_y ? port_t'(P_N) : port_t'(P_L);
`endif
   end

   // Scan from lowest to highest priority so the last hit (closest to ptr) wins.
   always_comb begin
      gnt = '0;
      pop = '0;
      for (int o = 0; o < NPORTS; o++) begin
         win[o] = '0;
         for (int k = NPORTS - 1; k >= 0; k--)
            if (free[o] && hv[rr_idx(ptr[o], k)] && dir[rr_idx(ptr[o], k)] == port_t'(o)) begin
               gnt[o] = 1'b1;
               win[o] = rr_idx(ptr[o], k);
            end
         if (gnt[o]) pop[win[o]] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         alive <= 1'b0;
         out_valid <= '0;
         for (int o = 0; o < NPORTS; o++) begin
            ptr[o] <= '0;
            oq[o] <= '0;
         end
      end else begin
         alive <= 1'b1;
         for (int o = 0; o < NPORTS; o++)
            if (gnt[o]) begin
               oq[o] <= head[win[o]];
               out_valid[o] <= 1'b1;
               ptr[o] <= rr_idx(win[o], 1);
            end else if (out_ready[o]) out_valid[o] <= 1'b0;
      end
endmodule

// File: tb/tb_torus_router_p.sv
// tb_torus_router_p: table-driven routing vectors, directed corner sequences and a randomized scoreboard run
module tb_torus_router_p;
   import torus_pkg::*;
   localparam int NX = 4, NY = 4, DW = 8, DEPTH = 4;
   localparam int XW = 2, YW = 2, FW = XW + YW + DW;
   typedef logic [FW-1:0] flit_t;
   typedef struct {int mx; int my; int dx; int dy; int pay; int p_mesh; int p_wrap;} rvec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [XW-1:0] my_x;
   logic [YW-1:0] my_y;
   logic [5*FW-1:0] in_data, out_data;
   logic [4:0] in_valid, in_ready, out_valid, out_ready;
   int n_vec = 0, n_bad = 0;

   always #5 clk = ~clk;

   torus_router_p #(.NX(NX), .NY(NY), .DW(DW), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst(rst),
      .my_x(my_x),
      .my_y(my_y),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic flit_t mk(int dx, int dy, int pay);
      return {XW'(dx), YW'(dy), DW'(pay)};
   endfunction

   // Expected output port straight from the routing rules.
   function automatic int ref_port(int mx, int myy, int dx, int dy);
`ifdef TORUS_WRAP_EN
      int ex, ey;
      ex = ((dx - mx) % NX + NX) % NX;
      ey = ((dy - myy) % NY + NY) % NY;
      if (ex != 0) return ex <= NX / 2 ? P_E : P_W;
      if (ey == 0) return P_L;
      return ey <= NY / 2 ? P_S : P_N;
`else
      if (dx != mx) return dx > mx ? P_E : P_W;
      if (dy == myy) return P_L;
      return dy > myy ? P_S : P_N;
`endif
   endfunction

   task automatic do_reset(input int mx, input int myy);
      in_valid = '0;
      in_data = '0;
      out_ready = '1;
      my_x = XW'(mx);
      my_y = YW'(myy);
      #2 rst = 1'b0;
      #7 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rvec_t rt [10];
      flit_t mq [NPORTS][NPORTS][$];
      logic hold [NPORTS];
      flit_t pd [NPORTS];
      int seq [NPORTS];
      int acc, got, left;
      logic [4:0] seen;
      rt[0] = '{1, 1, 3, 1, 'hA5, P_E, P_E};
      rt[1] = '{0, 0, 3, 0, 'h3C, P_E, P_W};
      rt[2] = '{1, 1, 1, 1, 'h5A, P_L, P_L};
      rt[3] = '{2, 2, 2, 3, 'h11, P_S, P_S};
      rt[4] = '{2, 2, 2, 0, 'h22, P_N, P_S};
      rt[5] = '{3, 3, 0, 3, 'h33, P_W, P_E};
      rt[6] = '{1, 0, 1, 3, 'h44, P_S, P_N};
      rt[7] = '{2, 1, 0, 2, 'h55, P_W, P_E};
      rt[8] = '{0, 3, 0, 0, 'h66, P_N, P_S};
      rt[9] = '{3, 0, 1, 2, 'h77, P_W, P_E};
      my_x = '0;
      my_y = '0;
      in_valid = '0;
      in_data = '0;
      out_ready = '1;
      #1 rst = 1'b0;
      #2;
      chk("reset_out_valid", 64'(out_valid), 64'(0));
      chk("reset_in_ready", 64'(in_ready), 64'(0));
      chk("reset_out_data", 64'(out_data), 64'(0));
      @(negedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("ready_after_reset", 64'(in_ready), 64'(5'b11111));

      for (int v = 0; v < 10; v++) begin
         int ep;
`ifdef TORUS_WRAP_EN
         ep = rt[v].p_wrap;
`else
         ep = rt[v].p_mesh;
`endif
         do_reset(rt[v].mx, rt[v].my);
         in_data[0 +: FW] = mk(rt[v].dx, rt[v].dy, rt[v].pay);
         in_valid = 5'b00001;
         @(negedge clk);
         in_valid = '0;
         chk($sformatf("route%0d_not_early", v), 64'(out_valid), 64'(0));
         @(negedge clk);
         chk($sformatf("route%0d_valid", v), 64'(out_valid), 64'(5'b00001 << ep));
         chk($sformatf("route%0d_data", v), 64'(out_data[ep*FW +: FW]), 64'(mk(rt[v].dx, rt[v].dy, rt[v].pay)));
      end

      do_reset(1, 1);
      in_data[1*FW +: FW] = mk(1, 1, 'h11);
      in_data[3*FW +: FW] = mk(1, 1, 'h33);
      in_data[4*FW +: FW] = mk(1, 1, 'h44);
      in_valid = 5'b11010;
      @(negedge clk);
      in_valid = '0;
      for (int j = 0; j < 3; j++) begin
         int pay;
         pay = j == 0 ? 'h11 : j == 1 ? 'h33 : 'h44;
         @(negedge clk);
         chk($sformatf("rr_local%0d", j), 64'({out_valid[0], out_data[0 +: FW]}), 64'({1'b1, mk(1, 1, pay)}));
      end

      do_reset(1, 1);
      out_ready = 5'b01111;
      acc = 0;
      for (int c = 0; c < 8; c++) begin
         in_data[0 +: FW] = mk(1, 2, acc);
         in_valid[0] = acc < 6;
         if (in_valid[0] && in_ready[0]) acc++;
         @(negedge clk);
      end
      in_valid = '0;
      chk("full_accepted", 64'(acc), 64'(5));
      chk("full_ready_low", 64'(in_ready[0]), 64'(0));
      chk("full_out_held", 64'({out_valid[4], out_data[4*FW +: FW]}), 64'({1'b1, mk(1, 2, 0)}));
      out_ready = '1;
      got = 0;
      for (int c = 0; c < 20; c++) begin
         if (out_valid[4]) begin
            chk($sformatf("drain%0d", got), 64'(out_data[4*FW +: FW]), 64'(mk(1, 2, got)));
            got++;
         end
         @(negedge clk);
      end
      chk("drain_count", 64'(got), 64'(5));

      do_reset(1, 1);
      out_ready = '0;
      for (int c = 0; c < 3; c++) begin
         in_data[0 +: FW] = mk(1, 2, c + 8);
         in_data[1*FW +: FW] = mk(1, 1, c + 16);
         in_valid = 5'b00011;
         @(negedge clk);
      end
      in_valid = '0;
      chk("pre_reset_busy", 64'(out_valid), 64'(5'b10001));
      #2 rst = 1'b0;
      #1;
      chk("midreset_out_valid", 64'(out_valid), 64'(0));
      chk("midreset_in_ready", 64'(in_ready), 64'(0));
      chk("midreset_out_data", 64'(out_data), 64'(0));
      @(negedge clk);
      #2 rst = 1'b1;
      out_ready = '1;
      @(posedge clk);
      #1;
      chk("postreset_in_ready", 64'(in_ready), 64'(5'b11111));
      seen = '0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         seen |= out_valid;
      end
      chk("no_stale_flit", 64'(seen), 64'(0));

      do_reset($urandom_range(0, NX - 1), $urandom_range(0, NY - 1));
      for (int i = 0; i < NPORTS; i++) begin
         seq[i] = 0;
         hold[i] = 1'b0;
         pd[i] = '0;
      end
      for (int cyc = 0; cyc < 3100; cyc++) begin
         logic drain;
         drain = cyc >= 3000;
         for (int o = 0; o < NPORTS; o++)
            if (hold[o])
               chk($sformatf("hold%0d", o), 64'({out_valid[o], out_data[o*FW +: FW]}), 64'({1'b1, pd[o]}));
         for (int i = 0; i < NPORTS; i++) begin
            int dx, dy;
            dx = $urandom_range(0, NX - 1);
            dy = $urandom_range(0, NY - 1);
            in_valid[i] = !drain && $urandom_range(0, 1) == 1;
            in_data[i*FW +: FW] = mk(dx, dy, i * 32 + seq[i] % 32);
            out_ready[i] = drain || $urandom_range(0, 3) != 0;
         end
         for (int i = 0; i < NPORTS; i++)
            if (in_valid[i] && in_ready[i]) begin
               flit_t f;
               f = in_data[i*FW +: FW];
               mq[i][ref_port(int'(my_x), int'(my_y), int'(f[FW-1 -: XW]), int'(f[DW +: YW]))].push_back(f);
               seq[i]++;
            end
         for (int o = 0; o < NPORTS; o++) begin
            if (out_valid[o] && out_ready[o]) begin
               flit_t f;
               int s;
               f = out_data[o*FW +: FW];
               s = int'(f[DW-1 -: 3]);
               if (s >= NPORTS || mq[s][o].size() == 0) begin
                  n_vec++;
                  n_bad++;
                  $display("FAIL rand_out%0d: got %0h, expected no flit (none outstanding)", o, f);
               end else chk($sformatf("rand_out%0d", o), 64'(f), 64'(mq[s][o].pop_front()));
            end
            hold[o] = out_valid[o] && !out_ready[o];
            pd[o] = out_data[o*FW +: FW];
         end
         @(negedge clk);
      end
      left = 0;
      for (int i = 0; i < NPORTS; i++)
         for (int o = 0; o < NPORTS; o++) left += mq[i][o].size();
      chk("rand_all_delivered", 64'(left), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
